// File: rtl/jtag_master_pkg.sv
// rtl/jtag_master_pkg.sv - shared op/state enums, TMS walk patterns and debug IR opcodes
package jtag_master_pkg;

  typedef enum logic [1:0] {
    OP_RESET    = 2'd0,
    OP_SHIFT_IR = 2'd1,
    OP_SHIFT_DR = 2'd2,
    OP_IDLE     = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_DONE
  } state_e;

  // TMS patterns, bit0 is driven on the first TCK of the phase
  localparam logic [5:0] TMS_PRE_RESET = 6'b011111;
  localparam logic [3:0] TMS_PRE_IR    = 4'b0011;
  localparam logic [2:0] TMS_PRE_DR    = 3'b001;
  localparam logic [1:0] TMS_POST      = 2'b01;

  localparam int IR_LEN = 3;

  typedef enum logic [IR_LEN-1:0] {
    IR_IDCODE = 3'b001,
    IR_DTMCS  = 3'b010,
    IR_DMI    = 3'b011,
    IR_BYPASS = 3'b111
  } ir_e;

  function automatic logic pre_tms(op_e op, logic [2:0] step);
    case (op)
      OP_RESET:    return TMS_PRE_RESET[step];
      OP_SHIFT_IR: return TMS_PRE_IR[step[1:0]];
      OP_SHIFT_DR: return TMS_PRE_DR[step[1:0]];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - TCK divider with one-CLK rise/fall strobes, held low while disabled
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          tck_q;
  logic          half_end;

  assign half_end = en_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (half_end) begin
      cnt_q <= '0;
      tck_q <= ~tck_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Strobes mark the CLK edge on which TCK toggles
  assign tck_o  = tck_q;
  assign rise_o = half_end && !tck_q;
  assign fall_o = half_end && tck_q;

endmodule

// File: rtl/jtag_master.sv
// rtl/jtag_master.sv - command-driven JTAG master: walks the TAP from RTI, shifts IR/DR, returns to RTI
module jtag_master
  import jtag_master_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
  input  logic [MAX_LEN-1:0]           cmd_data,
  output logic                         rsp_valid,
  output logic [MAX_LEN-1:0]           rsp_data,
  output logic                         TCK,
  output logic                         TMS,
  output logic                         TDI,
  input  logic                         TDO
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e             state_q, state_d;
  op_e                op_q;
  logic [LW-1:0]      len_q, step_q, len_eff, pre_last;
  logic [MAX_LEN-1:0] sh_q, cap_q, rsp_q;
  logic               busy, tck_rise, tck_fall, acc;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk_i  (CLK),
    .rst_i  (RST),
    .en_i   (busy),
    .tck_o  (TCK),
    .rise_o (tck_rise),
    .fall_o (tck_fall)
  );

  assign acc = cmd_valid && cmd_ready;

  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == '0)
      len_eff = LW'(1);
    else if (cmd_len > LW'(MAX_LEN))
      len_eff = LW'(MAX_LEN);
  end

  // RESET and IDLE ops do all their clocking in PRE and skip SHIFT/POST
  always_comb begin
    case (op_q)
      OP_RESET:    pre_last = LW'(5);
      OP_SHIFT_IR: pre_last = LW'(3);
      OP_SHIFT_DR: pre_last = LW'(2);
      default:     pre_last = len_q - LW'(1);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    TMS       = 1'b1;
    TDI       = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE, ST_DONE: begin
        cmd_ready = 1'b1;
        rsp_valid = (state_q == ST_DONE);
        state_d   = cmd_valid ? ST_PRE : ST_IDLE;
      end
      ST_PRE: begin
        busy = 1'b1;
        TMS  = pre_tms(op_q, step_q[2:0]);
        if (tck_fall && step_q == pre_last)
          state_d = (op_q == OP_SHIFT_IR || op_q == OP_SHIFT_DR) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        TMS  = (step_q == len_q - LW'(1));
        TDI  = sh_q[0];
        if (tck_fall && TMS)
          state_d = ST_POST;
      end
      ST_POST: begin
        busy = 1'b1;
        TMS  = TMS_POST[step_q[0]];
        if (tck_fall && step_q[0])
          state_d = ST_DONE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RESET;
      op_q    <= OP_RESET;
      len_q   <= '0;
      step_q  <= '0;
      sh_q    <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        op_q   <= op_e'(cmd_op);
        len_q  <= len_eff;
        step_q <= '0;
        sh_q   <= cmd_data;
        cap_q  <= '0;
      end else begin
        if (tck_rise && state_q == ST_SHIFT)
          cap_q[step_q[IW-1:0]] <= TDO;
        if (tck_fall) begin
          if (state_q == ST_SHIFT)
            sh_q <= sh_q >> 1;
          step_q <= (state_d != state_q) ? '0 : step_q + LW'(1);
        end
      end
      if (state_d == ST_DONE && state_q != ST_DONE)
        rsp_q <= cap_q;
    end
  end

  assign rsp_data = rsp_q;

endmodule
